// File: rtl/cdr_pi_ctrl.sv
// Bang-bang CDR phase-interpolator controller: vote accumulator, acquire/track/hold FSM.
// Define CDR_PI_NOWRAP_EN to saturate the PI code at 0/63 instead of wrapping modulo 64.
module cdr_pi_ctrl #(
  parameter int          THR_ACQ      = 2,
  parameter int          THR_TRK      = 8,
  parameter int          LOCK_CNT     = 64,
  parameter int          UNLOCK_STEPS = 4,
  parameter logic [5:0]  INIT_CODE    = 6'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       early,
  input  logic       late,
  input  logic       vote_valid,
  input  logic       freeze,
  output logic [5:0] vs,
  output logic       upd,
  output logic       lock
);

  localparam int THR_MAX = (THR_ACQ > THR_TRK) ? THR_ACQ : THR_TRK;
  localparam int ACC_W   = $clog2(THR_MAX + 1) + 2;
  localparam int LCNT_W  = $clog2(LOCK_CNT + 1);
  localparam int SCNT_W  = $clog2(UNLOCK_STEPS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                    state_reg, state_next;
  state_t                    saved_reg, saved_next;
  logic signed [ACC_W-1:0]   acc_reg, acc_next;
  logic [5:0]                vs_reg, vs_next;
  logic                      upd_reg, upd_next;
  logic                      lock_reg, lock_next;
  logic [LCNT_W-1:0]         lcnt_reg, lcnt_next;
  logic [SCNT_W-1:0]         scnt_reg, scnt_next;
  logic                      dir_reg, dir_next;

  logic [1:0]                net;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   thr;
  logic                      step_up, step_dn;
  logic [5:0]                vs_inc, vs_dec, vs_step;
  logic [LCNT_W-1:0]         lcnt_inc;
  logic [SCNT_W-1:0]         scnt_step;

  // Net vote as a 2-bit two's-complement value: +1 early, -1 late, else 0.
  always_comb begin
    net = 2'b00;
    if (vote_valid && early && !late)
      net = 2'b01;
    else if (vote_valid && late && !early)
      net = 2'b11;
  end

  assign sum      = acc_reg + {{(ACC_W-2){net[1]}}, net};
  assign thr      = (state_reg == TRACK) ? ACC_W'(THR_TRK) : ACC_W'(THR_ACQ);
  assign step_up  = (sum >= thr);
  assign step_dn  = (sum <= -thr);
  assign lcnt_inc = lcnt_reg + LCNT_W'(1);

`ifdef CDR_PI_NOWRAP_EN
  assign vs_inc = (vs_reg == 6'd63) ? vs_reg : vs_reg + 6'd1;
  assign vs_dec = (vs_reg == 6'd0)  ? vs_reg : vs_reg - 6'd1;
`else
  assign vs_inc = vs_reg + 6'd1;
  assign vs_dec = vs_reg - 6'd1;
`endif

  assign vs_step = step_up ? vs_inc : vs_dec;

  // A step attempt (even one blocked at a limit) extends the same-direction run.
  assign scnt_step = (scnt_reg != '0 && dir_reg == step_up) ? scnt_reg + SCNT_W'(1)
                                                            : SCNT_W'(1);

  always_comb begin
    state_next = state_reg;
    saved_next = saved_reg;
    acc_next   = acc_reg;
    vs_next    = vs_reg;
    upd_next   = 1'b0;
    lock_next  = lock_reg;
    lcnt_next  = lcnt_reg;
    scnt_next  = scnt_reg;
    dir_next   = dir_reg;

    case (state_reg)
      IDLE: begin
        if (vote_valid)
          state_next = ACQ;
      end

      ACQ, TRACK: begin
        if (freeze) begin
          saved_next = state_reg;
          state_next = HOLD;
        end else if (step_up || step_dn) begin
          vs_next  = vs_step;
          upd_next = (vs_step != vs_reg);
          acc_next = '0;
          if (state_reg == ACQ) begin
            lcnt_next = '0;
          end else begin
            dir_next  = step_up;
            scnt_next = scnt_step;
            if (scnt_step == SCNT_W'(UNLOCK_STEPS)) begin
              state_next = ACQ;
              lock_next  = 1'b0;
              scnt_next  = '0;
              lcnt_next  = '0;
            end
          end
        end else begin
          acc_next = sum;
          if (state_reg == ACQ) begin
            if (!vote_valid) begin
              lcnt_next = '0;
            end else if (lcnt_inc == LCNT_W'(LOCK_CNT)) begin
              state_next = TRACK;
              lock_next  = 1'b1;
              lcnt_next  = '0;
              scnt_next  = '0;
            end else begin
              lcnt_next = lcnt_inc;
            end
          end
        end
      end

      HOLD: begin
        if (!freeze)
          state_next = saved_reg;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      saved_reg <= IDLE;
      acc_reg   <= '0;
      vs_reg    <= INIT_CODE;
      upd_reg   <= 1'b0;
      lock_reg  <= 1'b0;
      lcnt_reg  <= '0;
      scnt_reg  <= '0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      saved_reg <= saved_next;
      acc_reg   <= acc_next;
      vs_reg    <= vs_next;
      upd_reg   <= upd_next;
      lock_reg  <= lock_next;
      lcnt_reg  <= lcnt_next;
      scnt_reg  <= scnt_next;
      dir_reg   <= dir_next;
    end
  end

  assign vs   = vs_reg;
  assign upd  = upd_reg;
  assign lock = lock_reg;

endmodule

// File: tb/tb_cdr_pi_ctrl.sv
// Scoreboard bench for cdr_pi_ctrl: stimulus queues expected outputs, a monitor pops and checks.
module tb_cdr_pi_ctrl;

  logic       clk = 1'b0;
  logic       rst, early, late, vote_valid, freeze;
  logic [5:0] vs;
  logic       upd, lock;

`ifdef CDR_PI_NOWRAP_EN
  localparam logic [5:0] WR = 6'd0;
  localparam logic       WU = 1'b0;
  localparam logic [5:0] V0 = 6'd1;
`else
  localparam logic [5:0] WR = 6'd63;
  localparam logic       WU = 1'b1;
  localparam logic [5:0] V0 = 6'd0;
`endif
  localparam logic [5:0] V1 = V0 + 6'd5;

  typedef struct {
    logic [5:0] vs;
    logic       upd;
    logic       lock;
    int         id;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   next_id = 0;

  cdr_pi_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .early      (early),
    .late       (late),
    .vote_valid (vote_valid),
    .freeze     (freeze),
    .vs         (vs),
    .upd        (upd),
    .lock       (lock)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic e, input logic l, input logic v,
                     input logic f, input logic [5:0] ev, input logic eu, input logic el);
    exp_t t;
    @(negedge clk);
    rst = r; early = e; late = l; vote_valid = v; freeze = f;
    t.vs = ev; t.upd = eu; t.lock = el; t.id = next_id;
    next_id++;
    q.push_back(t);
  endtask

  // Monitor: every transaction's outputs are visible just after the edge that consumed it.
  always @(posedge clk) begin
    exp_t t;
    logic ok;
    #1;
    if (q.size() != 0) begin
      t  = q.pop_front();
      ok = 1'b1;
      n_tests++;
      if (vs !== t.vs) begin
        n_fail++; ok = 1'b0;
        $display("[TB] FAIL vs txn %0d: got %0d expected %0d", t.id, vs, t.vs);
      end
      n_tests++;
      if (upd !== t.upd) begin
        n_fail++; ok = 1'b0;
        $display("[TB] FAIL upd txn %0d: got %b expected %b", t.id, upd, t.upd);
      end
      n_tests++;
      if (lock !== t.lock) begin
        n_fail++; ok = 1'b0;
        $display("[TB] FAIL lock txn %0d: got %b expected %b", t.id, lock, t.lock);
      end
      if (ok)
        $display("[TB] txn %0d vs=%0d upd=%b lock=%b ok", t.id, vs, upd, lock);
    end
  end

  initial begin
    int guard;
    rst = 1'b1; early = 1'b0; late = 1'b0; vote_valid = 1'b0; freeze = 1'b0;

    // Reset, including reset with votes present
    cyc(1, 0, 0, 0, 0, 6'd0, 0, 0);
    cyc(1, 1, 0, 1, 0, 6'd0, 0, 0);

    // First vote leaves IDLE unaccumulated, then one step per two early votes
    cyc(0, 1, 0, 1, 0, 6'd0, 0, 0);
    cyc(0, 1, 0, 1, 0, 6'd0, 0, 0);
    cyc(0, 1, 0, 1, 0, 6'd1, 1, 0);
    cyc(0, 1, 0, 1, 0, 6'd1, 0, 0);
    cyc(0, 1, 0, 1, 0, 6'd2, 1, 0);

    // Walk down through 0 (wrap or saturate), then back up
    cyc(0, 0, 1, 1, 0, 6'd2, 0, 0);
    cyc(0, 0, 1, 1, 0, 6'd1, 1, 0);
    cyc(0, 0, 1, 1, 0, 6'd1, 0, 0);
    cyc(0, 0, 1, 1, 0, 6'd0, 1, 0);
    cyc(0, 0, 1, 1, 0, 6'd0, 0, 0);
    cyc(0, 0, 1, 1, 0, WR,   WU, 0);
    cyc(0, 1, 0, 1, 0, WR,   0, 0);
    cyc(0, 1, 0, 1, 0, V0,   1, 0);

    // Unqualified vote and contradictory vote both contribute nothing
    cyc(0, 1, 0, 0, 0, V0, 0, 0);
    cyc(0, 1, 1, 1, 0, V0, 0, 0);

    for (int i = 0; i < 10; i++)
      cyc(0, 1, 0, 1, 0, 6'(V0 + (i + 1) / 2), (i % 2 == 1), 0);

    // 64 alternating votes: no steps, lock after the 64th
    for (int i = 0; i < 64; i++)
      cyc(0, (i % 2 == 0), (i % 2 == 1), 1, 0, V1, 0, (i == 63));

    // Freeze in TRACK: everything held, lock stays
    for (int i = 0; i < 20; i++)
      cyc(0, 1, 0, 1, 1, V1, 0, 1);
    cyc(0, 0, 0, 0, 0, V1, 0, 1);

    // Back in TRACK with acc still zero: threshold 8
    for (int i = 0; i < 8; i++)
      cyc(0, 1, 0, 1, 0, 6'(V1 + (i == 7)), (i == 7), 1);

    // 32 late votes: 4 same-direction steps drop lock
    for (int i = 0; i < 32; i++)
      cyc(0, 0, 1, 1, 0, 6'(V1 + 1 - (i + 1) / 8), (i % 8 == 7), (i != 31));

    // Back in ACQ: threshold 2 again
    cyc(0, 1, 0, 1, 0, 6'(V1 - 3), 0, 0);
    cyc(0, 1, 0, 1, 0, 6'(V1 - 2), 1, 0);

    // Freeze wins over a threshold crossing in ACQ
    cyc(0, 1, 0, 1, 0, 6'(V1 - 2), 0, 0);
    cyc(0, 1, 0, 1, 1, 6'(V1 - 2), 0, 0);
    cyc(0, 0, 0, 0, 0, 6'(V1 - 2), 0, 0);
    cyc(0, 1, 0, 1, 0, 6'(V1 - 1), 1, 0);
    cyc(0, 1, 0, 1, 0, 6'(V1 - 1), 0, 0);

    // Reset wins over a threshold crossing
    cyc(1, 1, 0, 1, 0, 6'd0, 0, 0);

    // Freeze has no effect in IDLE
    cyc(0, 1, 0, 1, 1, 6'd0, 0, 0);
    cyc(0, 1, 0, 1, 0, 6'd0, 0, 0);
    cyc(0, 1, 0, 1, 0, 6'd1, 1, 0);

    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d transactions unchecked, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdr_pi_ctrl.md
CDR_PI_CTRL -- requirements
Module: cdr_pi_ctrl

Interface
REQ-001 SHALL have parameter THR_ACQ, default 2, which is the vote-accumulator step threshold in ACQ.
REQ-002 SHALL have parameter THR_TRK, default 8, which is the vote-accumulator step threshold in TRACK.
REQ-003 SHALL have parameter LOCK_CNT, default 64, which is the number of consecutive valid votes without a step needed to declare lock.
REQ-004 SHALL have parameter UNLOCK_STEPS, default 4, which is the number of consecutive same-direction steps in TRACK that declares loss of lock.
REQ-005 SHALL have parameter INIT_CODE, default 6'd0, which is the vs value on reset.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port early, input, 1 bit: phase-detector vote that the sample is early.
REQ-009 SHALL have port late, input, 1 bit: phase-detector vote that the sample is late.
REQ-010 SHALL have port vote_valid, input, 1 bit: qualifies early/late in the current cycle.
REQ-011 SHALL have port freeze, input, 1 bit: suspends loop update.
REQ-012 SHALL have port vs, output, 6 bits: phase-interpolator code; vs[5:4] selects quadrant 0/90/180/270 and vs[3:0] is the fine step.
REQ-013 SHALL have port upd, output, 1 bit: one-cycle pulse in the cycle vs changes.
REQ-014 SHALL have port lock, output, 1 bit: loop is in TRACK.

Function
REQ-015 SHALL form net vote = +1 (early only), -1 (late only), 0 (both, neither, or vote_valid=0).
REQ-016 SHALL hold a signed accumulator acc; each edge computes s = acc + net against threshold T (THR_ACQ in ACQ, THR_TRK in TRACK).
REQ-017 SHALL, when s >= +T: increment vs, clear acc to 0, and pulse upd, all on the same edge.
REQ-018 SHALL, when s <= -T: decrement vs, clear acc to 0, and pulse upd, all on the same edge.
REQ-019 SHALL otherwise load acc = s and leave vs unchanged; latency is vote sampled at edge k to vs updated at edge k, so vs is registered and visible after edge k.
REQ-020 SHALL use the states IDLE, ACQ, TRACK and HOLD, encoded in 2 bits.
REQ-021 SHALL, in IDLE, ignore votes and move to ACQ on the first vote_valid=1; that vote is not accumulated.
REQ-022 SHALL, in ACQ, count consecutive vote_valid cycles with no step; count reaching LOCK_CNT goes to TRACK and sets lock=1, and any step clears the count.
REQ-023 SHALL, in TRACK, count consecutive same-direction steps; a direction change resets the count to 1, and count reaching UNLOCK_STEPS goes to ACQ, clears lock and clears acc.
REQ-024 SHALL, on freeze=1 in ACQ or TRACK, enter HOLD: votes are ignored, acc, vs and counters are held, upd=0, and the prior state is saved.
REQ-025 SHALL, on freeze=0 in HOLD, return to the saved state; lock remains valid throughout a HOLD entered from TRACK.
REQ-026 SHALL, on simultaneous freeze=1 and a threshold crossing, give freeze priority: no step occurs and the vote is discarded.
REQ-027 SHALL treat freeze in IDLE as no effect.
REQ-028 SHALL, on simultaneous lock-count completion and a step in ACQ, take the step and not transition.

Reset
REQ-029 SHALL, on rst=1 at a rising edge, set state to IDLE, vs to INIT_CODE, acc and all counters to 0, and upd and lock to 0.
REQ-030 SHALL give rst priority over all inputs, including mid-HOLD and mid-step.
REQ-031 SHALL make outputs valid on the first edge after reset.

Configuration
REQ-032 SHALL support macro CDR_PI_NOWRAP_EN.
REQ-033 SHALL, when CDR_PI_NOWRAP_EN is undefined, wrap vs modulo 64 (63+1 goes to 0, 0-1 goes to 63, continuous quadrant rotation), with upd pulsing on wrap.
REQ-034 SHALL, when CDR_PI_NOWRAP_EN is defined, saturate vs at 0 and 63; a step at a limit leaves vs unchanged, upd=0, acc cleared, and the attempted step still counts toward UNLOCK_STEPS.

Verification
REQ-035 SHALL cover: reset, then vote_valid=1 with early=1 for 5 cycles (defaults) -> IDLE consumes 1 vote, then vs goes 0->1->2 with upd on the 3rd and 5th cycles.
REQ-036 SHALL cover: alternating early/late votes for 64 cycles in ACQ -> lock=1 after the 64th vote and T switches to 8.
REQ-037 SHALL cover: in TRACK, 32 consecutive late votes -> 4 decrements, then lock=0 with state ACQ.
REQ-038 SHALL cover: vs=63 with 2 early votes in ACQ -> vs=0 and upd=1 without the macro; vs=63 and upd=0 with CDR_PI_NOWRAP_EN.
REQ-039 SHALL cover: freeze=1 in TRACK during 20 early votes -> vs, acc and lock unchanged; after freeze=0 the state is TRACK.
REQ-040 SHALL cover: rst asserted in the same cycle as a threshold crossing -> vs=INIT_CODE, upd=0, state IDLE.
